seg_display_mux: RTL and testbench

Downstream consumer of the stopwatch counter's four BCD digits (min1, min0, sec1, sec0). Time-multiplexes them onto a 4-digit common-anode 7-segment display. Blinks the field being adjusted while adjust mode is active. Registered outputs drive board pins directly.

---
 rtl/seg_display_mux_pkg.sv | 61 ++++++
 rtl/seg_display_mux_if.sv | 26 ++
 rtl/seg_display_mux_decode.sv | 27 ++
 rtl/seg_display_mux.sv | 106 ++++++++++
 tb/tb_seg_display_mux.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/seg_display_mux_pkg.sv
// Shared constants and types for the 4-digit 7-segment display multiplexer.
package seg_display_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned AN_W    = 4;
  localparam int unsigned IDX_W   = 2;

  typedef logic [SEG_W-1:0]   seg_t;
  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [AN_W-1:0]    an_t;
  typedef logic [IDX_W-1:0]   idx_t;

  // Four BCD digits of one display frame.
  typedef struct packed {
    digit_t min1;
    digit_t min0;
    digit_t sec1;
    digit_t sec0;
  } digits_t;

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Digit slot indices, rightmost first.
  localparam idx_t IDX_SEC0 = 2'd0;
  localparam idx_t IDX_SEC1 = 2'd1;
  localparam idx_t IDX_MIN0 = 2'd2;
  localparam idx_t IDX_MIN1 = 2'd3;

  // Active-low anode patterns per slot.
  localparam an_t AN_SEC0 = 4'b1110;
  localparam an_t AN_SEC1 = 4'b1101;
  localparam an_t AN_MIN0 = 4'b1011;
  localparam an_t AN_MIN1 = 4'b0111;
  localparam an_t AN_OFF  = 4'b1111;

  // Anode pattern for a slot index.
  function automatic an_t an_for(input idx_t idx);
    an_t an;
    case (idx)
      IDX_SEC0: an = AN_SEC0;
      IDX_SEC1: an = AN_SEC1;
      IDX_MIN0: an = AN_MIN0;
      default:  an = AN_MIN1;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/seg_display_mux_if.sv
// Digit inputs, adjust controls and display pin outputs of the display mux.
interface seg_display_mux_if;
  import seg_display_pkg::*;

  digit_t min1;
  digit_t min0;
  digit_t sec1;
  digit_t sec0;
  logic   adjust;
  logic   select;
  seg_t   seg;
  logic   dp;
  an_t    an;

  // Source of digits and adjust controls; sink of display pins.
  modport master (
    output min1, min0, sec1, sec0, adjust, select,
    input  seg, dp, an
  );

  // The display mux itself.
  modport slave (
    input  min1, min0, sec1, sec0, adjust, select,
    output seg, dp, an
  );
endinterface

// File: rtl/seg_display_mux_decode.sv
// Combinational BCD to active-low 7-segment decoder; 10..15 show a dash.
module seg7_decode
  import seg_display_pkg::*;
(
  input  digit_t value_i,
  output seg_t   seg_c_o
);

  // Value to segment lookup.
  always_comb begin
    seg_c_o = SEG_DASH;
    case (value_i)
      4'd0:    seg_c_o = SEG_0;
      4'd1:    seg_c_o = SEG_1;
      4'd2:    seg_c_o = SEG_2;
      4'd3:    seg_c_o = SEG_3;
      4'd4:    seg_c_o = SEG_4;
      4'd5:    seg_c_o = SEG_5;
      4'd6:    seg_c_o = SEG_6;
      4'd7:    seg_c_o = SEG_7;
      4'd8:    seg_c_o = SEG_8;
      4'd9:    seg_c_o = SEG_9;
      default: seg_c_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexes four BCD digits onto a common-anode 7-segment display,
// snapshotting the inputs once per frame and blinking the adjusted field.
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input logic              clk,
  input logic              reset,
  seg_display_mux_if.slave bus
);

  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  idx_t               idx_q, idx_d;
  logic               blink_phase_q, blink_phase_d;
  digits_t            snap_q, snap_d;
  seg_t               seg_q, seg_d;
  logic               dp_q, dp_d;
  an_t                an_q, an_d;

  digits_t            live;
  digits_t            src;
  digit_t             digit;
  seg_t               dec_seg;
  logic               frame_start;
  logic               scan_last;
  logic               blink_last;
  logic               blank_slot;
  logic               blank;

  assign live = '{min1: bus.min1, min0: bus.min0, sec1: bus.sec1, sec0: bus.sec0};

  seg7_decode u_decode (
    .value_i (digit),
    .seg_c_o (dec_seg)
  );

  // Next-state for scan, blink, snapshot and the display pin registers.
  always_comb begin
    frame_start   = (scan_cnt_q == '0) && (idx_q == IDX_SEC0);
    scan_last     = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    blink_last    = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    src           = frame_start ? live : snap_q;
    snap_d        = frame_start ? live : snap_q;
    scan_cnt_d    = scan_last ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d         = scan_last ? idx_q + IDX_W'(1) : idx_q;
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    digit         = src.sec0;
    blank_slot    = 1'b0;

    // Blink timing only runs in adjust mode so entry starts visible.
    if (bus.adjust) begin
      blink_cnt_d   = blink_last ? '0 : blink_cnt_q + BLINK_W'(1);
      blink_phase_d = blink_last ? ~blink_phase_q : blink_phase_q;
    end

    case (idx_q)
      IDX_SEC0: digit = src.sec0;
      IDX_SEC1: digit = src.sec1;
      IDX_MIN0: digit = src.min0;
      default:  digit = src.min1;
    endcase

    blank_slot = bus.select ? ((idx_q == IDX_SEC0) || (idx_q == IDX_SEC1))
                            : ((idx_q == IDX_MIN0) || (idx_q == IDX_MIN1));
    blank      = bus.adjust && blink_phase_q && blank_slot;

    seg_d = blank ? SEG_BLANK : dec_seg;
    dp_d  = blank || (idx_q != IDX_MIN0);
    an_d  = an_for(idx_q);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q    <= '0;
      idx_q         <= IDX_SEC0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      snap_q        <= '0;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      an_q          <= AN_OFF;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      snap_q        <= snap_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with a cycle-level reference model
// feeding an expected-output scoreboard queue.
module tb_seg_display_mux;
  import seg_display_pkg::*;

  localparam int unsigned SD = 4;
  localparam int unsigned BD = 8;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  seg_display_mux_if bus ();

  seg_display_mux #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected display pins {seg, dp, an}.
  logic [11:0] exp_q[$];

  // Reference model state: cycles since reset, adjust-active cycles, frame copy.
  int      t;
  int      a;
  digit_t  m_min1, m_min0, m_sec1, m_sec0;
  seg_t    dec_tab [16];

  function automatic seg_t ref_seg(input digit_t v);
    return dec_tab[v];
  endfunction

  task automatic cycle(input string tag);
    int          slot;
    digit_t      d;
    logic        blank;
    seg_t        e_seg;
    logic        e_dp;
    an_t         e_an;
    logic [11:0] obs;
    logic [11:0] exp;
    if (reset) begin
      e_seg = 7'b1111111;
      e_dp  = 1'b1;
      e_an  = 4'b1111;
    end else begin
      slot = (t / SD) % 4;
      if (t % (4 * SD) == 0) begin
        m_min1 = bus.min1; m_min0 = bus.min0; m_sec1 = bus.sec1; m_sec0 = bus.sec0;
      end
      case (slot)
        0:       d = m_sec0;
        1:       d = m_sec1;
        2:       d = m_min0;
        default: d = m_min1;
      endcase
      blank = bus.adjust && (((a / BD) % 2) == 1) &&
              (bus.select ? (slot < 2) : (slot >= 2));
      e_seg = blank ? 7'b1111111 : ref_seg(d);
      e_dp  = blank ? 1'b1 : (slot != 2);
      e_an  = ~(4'b0001 << slot);
    end
    exp_q.push_back({e_seg, e_dp, e_an});

    @(posedge clk);
    #1;
    if (reset) begin
      t = 0; a = 0;
      m_min1 = '0; m_min0 = '0; m_sec1 = '0; m_sec0 = '0;
    end else begin
      t = t + 1;
      a = bus.adjust ? a + 1 : 0;
    end

    obs = {bus.seg, bus.dp, bus.an};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s scoreboard empty obs=%b", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs[11:5] === exp[11:5]) else begin
        miscompares++;
        $error("FAIL %s seg t=%0d obs=%b exp=%b", tag, t, obs[11:5], exp[11:5]);
      end
      assert (obs[4] === exp[4]) else begin
        miscompares++;
        $error("FAIL %s dp t=%0d obs=%b exp=%b", tag, t, obs[4], exp[4]);
      end
      assert (obs[3:0] === exp[3:0]) else begin
        miscompares++;
        $error("FAIL %s an t=%0d obs=%b exp=%b", tag, t, obs[3:0], exp[3:0]);
      end
    end
  endtask

  initial begin
    dec_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    vectors = 0; miscompares = 0;
    t = 0; a = 0;
    m_min1 = '0; m_min0 = '0; m_sec1 = '0; m_sec0 = '0;

    reset = 1'b1;
    bus.min1 = 4'd1; bus.min0 = 4'd2; bus.sec1 = 4'd3; bus.sec0 = 4'd4;
    bus.adjust = 1'b0; bus.select = 1'b0;
    @(negedge clk);
    cycle("reset");
    cycle("reset");
    reset = 1'b0;

    // Plain scanning of 1 2 : 3 4.
    for (int i = 0; i < 24; i++) cycle("scan");

    // Mid-frame input change stays hidden until the next frame.
    cycle("tear");
    bus.sec0 = 4'd5;
    for (int i = 0; i < 23; i++) cycle("tear");

    // Out-of-range digit shows a dash.
    bus.min1 = 4'hC;
    for (int i = 0; i < 16; i++) cycle("dash");

    // Seconds field blinks, then minutes field.
    bus.adjust = 1'b1; bus.select = 1'b1;
    for (int i = 0; i < 32; i++) cycle("blink_sec");
    bus.select = 1'b0;
    for (int i = 0; i < 34; i++) cycle("blink_min");

    // Drop adjust while blanked, then re-raise.
    bus.adjust = 1'b0;
    for (int i = 0; i < 4; i++) cycle("adj_off");
    bus.adjust = 1'b1; bus.select = 1'b1;
    for (int i = 0; i < 20; i++) cycle("adj_on");

    // Reset pulse during slot 2 with fresh inputs.
    bus.adjust = 1'b0;
    while (((t / SD) % 4) != 2) cycle("seek");
    cycle("pre_rst");
    reset = 1'b1;
    bus.min1 = 4'd9; bus.min0 = 4'd8; bus.sec1 = 4'd0; bus.sec0 = 4'd7;
    cycle("rst_mid");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) cycle("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
